// File: rtl/delayed_branch_sched.sv
// delayed_branch_sched: queues delayed branches from a dual-issue fetch group,
// resolves the oldest one against the stage-3 flags two fetch groups later,
// and hands taken branches to the PC unit as a redirect followed by a flush.
//
// Build option: define DBS_PERF_CNT_EN to add perf_taken_cnt_out, a 16-bit
// wrapping count of accepted redirects. Without it the port and counter are
// absent and behaviour is otherwise unchanged.
`timescale 1ns/1ps

module delayed_branch_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_next_in,
  input  logic        p0_b_valid_in,
  input  logic        p1_b_valid_in,
  input  logic [7:0]  p0_dest_in,
  input  logic [7:0]  p1_dest_in,
  input  logic [2:0]  p0_cond_in,
  input  logic [2:0]  p1_cond_in,
  input  logic        N,
  input  logic        V,
  input  logic        Z,
  input  logic        flags_valid_in,
  input  logic        redirect_ready_in,
  output logic        redirect_valid_out,
  output logic [8:0]  redirect_pc_out,
  output logic        p0_do_delayed_B,
  output logic        p1_do_delayed_B,
  output logic        flush_out,
`ifdef DBS_PERF_CNT_EN
  output logic [15:0] perf_taken_cnt_out,
`endif
  output logic        stall_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESOLVE,
    ST_REDIRECT,
    ST_FLUSH
  } state_e;

  // One pending delayed branch; validity is implied by position < cnt_q.
  typedef struct packed {
    logic       slot;   // 0 = issued from p0, 1 = issued from p1
    logic [7:0] dest;
    logic [2:0] cond;
    logic [1:0] age;    // fetch groups seen since push, saturates at 2
  } entry_t;

  localparam logic [1:0] AGE_RESOLVE = 2'd2;

  state_e         state_q, state_d;
  entry_t [3:0]   fifo_q, fifo_d;   // index 0 is the head (oldest)
  logic   [2:0]   cnt_q, cnt_d;     // occupancy 0..4

  logic head_ready;
  logic head_taken;
  logic resolve;
  logic pop;
  logic handshake;
  logic push_ok;
  logic push0;
  logic push1;

  // Condition-code evaluation against the current stage-3 flags.
  function automatic logic cond_true(input logic [2:0] cond,
                                     input logic n, input logic v,
                                     input logic z);
    logic lt;
    lt = n ^ v;
    case (cond)
      3'd0:    cond_true = 1'b0;        // NV
      3'd1:    cond_true = 1'b1;        // AL
      3'd2:    cond_true = z;           // EQ
      3'd3:    cond_true = !z;          // NE
      3'd4:    cond_true = lt;          // LT
      3'd5:    cond_true = z | lt;      // LE
      3'd6:    cond_true = !z && !lt;   // GT
      default: cond_true = !lt;         // GE
    endcase
  endfunction

  // Fetch holds once three branches are pending so a full dual push fits.
  assign stall_out = (cnt_q >= 3'd3);

  // Per-cycle control decisions: resolve/pop of the head, redirect handshake, pushes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    head_ready = (cnt_q != 3'd0) && (fifo_q[0].age == AGE_RESOLVE);
    head_taken = cond_true(fifo_q[0].cond, N, V, Z);
    resolve    = (state_q == ST_RESOLVE) && head_ready && flags_valid_in;
    pop        = resolve && !head_taken;
    handshake  = (state_q == ST_REDIRECT) && redirect_ready_in;
    // Younger groups are wrong-path once a redirect is accepted or flushing.
    push_ok    = fetch_next_in && !stall_out && (state_q != ST_FLUSH) && !handshake;
    push0      = push_ok && p0_b_valid_in;
    push1      = push_ok && p1_b_valid_in;
  end

  // FIFO next state: age, then clear or pop, then push p0 before p1.
  always_comb begin
    fifo_d = fifo_q;
    cnt_d  = cnt_q;

    if (fetch_next_in) begin
      for (int i = 0; i < 4; i++) begin
        if ((3'(i) < cnt_q) && (fifo_d[i].age != AGE_RESOLVE)) begin
          fifo_d[i].age = fifo_d[i].age + 2'd1;
        end
      end
    end

    if (handshake) begin
      cnt_d = 3'd0;
    end else begin
      if (pop) begin
        for (int i = 0; i < 3; i++) begin
          fifo_d[i] = fifo_d[i+1];
        end
        cnt_d = cnt_d - 3'd1;
      end
      if (push0) begin
        fifo_d[cnt_d[1:0]] = '{slot: 1'b0, dest: p0_dest_in, cond: p0_cond_in, age: 2'd0};
        cnt_d = cnt_d + 3'd1;
      end
      if (push1) begin
        fifo_d[cnt_d[1:0]] = '{slot: 1'b1, dest: p1_dest_in, cond: p1_cond_in, age: 2'd0};
        cnt_d = cnt_d + 3'd1;
      end
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (head_ready) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_IDLE;
        end else if (resolve) begin
          if (head_taken)          state_d = ST_REDIRECT;
          else if (cnt_d == 3'd0)  state_d = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready_in) state_d = ST_FLUSH;
      end
      default: state_d = ST_IDLE;   // ST_FLUSH lasts exactly one cycle
    endcase
  end

  // FSM outputs; the head is frozen in REDIRECT, so the target stays stable.
  always_comb begin
    redirect_valid_out = 1'b0;
    redirect_pc_out    = 9'd0;
    p0_do_delayed_B    = 1'b0;
    p1_do_delayed_B    = 1'b0;
    flush_out          = 1'b0;
    case (state_q)
      ST_REDIRECT: begin
        redirect_valid_out = 1'b1;
        redirect_pc_out    = {1'b0, fifo_q[0].dest};
        p0_do_delayed_B    = !fifo_q[0].slot;
        p1_do_delayed_B    = fifo_q[0].slot;
      end
      ST_FLUSH: flush_out = 1'b1;
      default: ;
    endcase
  end

  // State and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: the entry array is deliberately not reset: cnt_q alone defines
    // which entries are valid, and nothing reads an entry beyond it.
    fifo_q <= fifo_d;
  end

`ifdef DBS_PERF_CNT_EN
  logic [15:0] perf_cnt_q, perf_cnt_d;

  // Count accepted redirects, wrapping naturally at 16 bits.
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (handshake) perf_cnt_d = perf_cnt_q + 16'd1;
  end

  // Performance counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_cnt_q <= 16'd0;
    else      perf_cnt_q <= perf_cnt_d;
  end

  assign perf_taken_cnt_out = perf_cnt_q;
`endif

endmodule

// File: tb/tb_delayed_branch_sched.sv
// Directed self-checking bench for delayed_branch_sched.
// Inputs change and outputs are checked 1 ns after each rising edge.
`timescale 1ns/1ps

module tb_delayed_branch_sched;

  localparam logic [2:0] C_NV = 3'd0, C_AL = 3'd1, C_EQ = 3'd2, C_LT = 3'd4,
                         C_LE = 3'd5, C_GT = 3'd6;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch;
  logic        p0v, p1v;
  logic [7:0]  p0d, p1d;
  logic [2:0]  p0c, p1c;
  logic        n_f, v_f, z_f, fv;
  logic        rdy;
  logic        rv;
  logic [8:0]  rpc;
  logic        p0_do, p1_do;
  logic        flush;
  logic        stall;
`ifdef DBS_PERF_CNT_EN
  logic [15:0] perf;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  delayed_branch_sched dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_next_in     (fetch),
    .p0_b_valid_in     (p0v),
    .p1_b_valid_in     (p1v),
    .p0_dest_in        (p0d),
    .p1_dest_in        (p1d),
    .p0_cond_in        (p0c),
    .p1_cond_in        (p1c),
    .N                 (n_f),
    .V                 (v_f),
    .Z                 (z_f),
    .flags_valid_in    (fv),
    .redirect_ready_in (rdy),
    .redirect_valid_out(rv),
    .redirect_pc_out   (rpc),
    .p0_do_delayed_B   (p0_do),
    .p1_do_delayed_B   (p1_do),
    .flush_out         (flush),
`ifdef DBS_PERF_CNT_EN
    .perf_taken_cnt_out(perf),
`endif
    .stall_out         (stall)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One fetch group carrying the given slot branches.
  task automatic push(input logic v0, input logic [7:0] d0, input logic [2:0] c0,
                      input logic v1, input logic [7:0] d1, input logic [2:0] c1);
    fetch = 1'b1;
    p0v = v0; p0d = d0; p0c = c0;
    p1v = v1; p1d = d1; p1c = c1;
    step();
    fetch = 1'b0; p0v = 1'b0; p1v = 1'b0;
  endtask

  task automatic fetch_only(input int n);
    fetch = 1'b1;
    step(n);
    fetch = 1'b0;
  endtask

  initial begin
    rst = 1'b0; fetch = 1'b0; p0v = 1'b0; p1v = 1'b0;
    p0d = 8'h00; p1d = 8'h00; p0c = 3'd0; p1c = 3'd0;
    n_f = 1'b0; v_f = 1'b0; z_f = 1'b0; fv = 1'b0; rdy = 1'b0;

    // Reset state
    step(2);
    check("rst_redirect_valid", rv, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_flush", flush, 1'b0);
    rst = 1'b1;

    // Taken EQ branch from p0, immediate handshake, one-cycle flush
    z_f = 1'b1; fv = 1'b1;
    push(1'b1, 8'h24, C_EQ, 1'b0, 8'h00, C_NV);
    fetch_only(2);
    step();                                   // IDLE -> RESOLVE
    check("eq_not_yet", rv, 1'b0);
    step();                                   // RESOLVE -> REDIRECT
    check("eq_redirect_valid", rv, 1'b1);
    check("eq_redirect_pc", rpc, 9'h024);
    check("eq_p0_do", p0_do, 1'b1);
    check("eq_p1_do", p1_do, 1'b0);
    rdy = 1'b1;
    step();                                   // handshake -> FLUSH
    rdy = 1'b0;
    check("eq_flush", flush, 1'b1);
    check("eq_valid_dropped", rv, 1'b0);
    step();
    check("eq_flush_one_cycle", flush, 1'b0);

    // Not-taken LT branch from p1 (N=V=1) pops silently
    n_f = 1'b1; v_f = 1'b1; z_f = 1'b0; fv = 1'b1;
    push(1'b0, 8'h00, C_NV, 1'b1, 8'h55, C_LT);
    fetch_only(2);
    step();                                   // RESOLVE
    step();                                   // pop, back to IDLE
    check("lt_no_redirect", rv, 1'b0);
    check("lt_no_flush", flush, 1'b0);
    step();
    check("lt_still_idle", rv, 1'b0);

    // Stall at occupancy 3, dropped push, release after a pop
    fv = 1'b0;
    push(1'b1, 8'h10, C_NV, 1'b1, 8'h11, C_NV);
    check("occ2_no_stall", stall, 1'b0);
    push(1'b1, 8'h12, C_AL, 1'b0, 8'h00, C_NV);
    check("occ3_stall", stall, 1'b1);
    push(1'b1, 8'h13, C_AL, 1'b0, 8'h00, C_NV);  // dropped
    check("occ3_stall_hold", stall, 1'b1);
    step();                                   // IDLE -> RESOLVE, waits for flags
    check("wait_flags_stall", stall, 1'b1);
    check("wait_flags_no_redirect", rv, 1'b0);
    fv = 1'b1;
    step();                                   // pop 0x10
    check("pop_releases_stall", stall, 1'b0);
    check("pop_no_redirect", rv, 1'b0);
    step();                                   // pop 0x11
    step();                                   // head 0x12 still age 1
    check("young_head_waits", rv, 1'b0);
    fetch_only(1);
    step();                                   // AL taken
    check("al_redirect_pc", rpc, 9'h012);
    check("al_p0_do", p0_do, 1'b1);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    step();

    // Taken GT head with two younger entries, ready held low 3 cycles
    n_f = 1'b0; v_f = 1'b0; z_f = 1'b0; fv = 1'b0;
    push(1'b1, 8'h30, C_GT, 1'b1, 8'h31, C_AL);
    push(1'b1, 8'h32, C_AL, 1'b0, 8'h00, C_NV);
    fetch_only(1);
    step();                                   // RESOLVE
    fv = 1'b1;
    step();                                   // REDIRECT
    check("gt_redirect_valid", rv, 1'b1);
    check("gt_redirect_pc", rpc, 9'h030);
    check("gt_stall_full", stall, 1'b1);
    z_f = 1'b1; n_f = 1'b1;                   // flags now say not-taken
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", rv, 1'b1);
      check("hold_pc", rpc, 9'h030);
    end
    rdy = 1'b1;
    step();                                   // handshake -> FLUSH
    rdy = 1'b0;
    check("gt_flush", flush, 1'b1);
    check("gt_fifo_cleared", stall, 1'b0);
`ifdef DBS_PERF_CNT_EN
    check("perf_three", perf, 16'd3);
`endif
    push(1'b1, 8'h40, C_AL, 1'b0, 8'h00, C_NV);  // offered during FLUSH, dropped
    check("gt_flush_done", flush, 1'b0);
    fetch_only(3);
    step();
    check("wrong_path_gone_a", rv, 1'b0);
    step();
    check("wrong_path_gone_b", rv, 1'b0);

    // Asynchronous reset in the middle of a p1 redirect
    push(1'b0, 8'h00, C_NV, 1'b1, 8'h77, C_AL);
    fetch_only(2);
    step(2);
    check("p1_redirect_pc", rpc, 9'h077);
    check("p1_do", p1_do, 1'b1);
    check("p1_p0_do_low", p0_do, 1'b0);
    #3 rst = 1'b0;
    #1;
    check("async_rst_valid", rv, 1'b0);
    check("async_rst_p1_do", p1_do, 1'b0);
    check("async_rst_pc", rpc, 9'h000);
`ifdef DBS_PERF_CNT_EN
    check("async_rst_perf", perf, 16'd0);
`endif
    step();
    rst = 1'b1;
    fetch_only(3);
    step();
    check("post_rst_empty_a", rv, 1'b0);
    step();
    check("post_rst_empty_b", rv, 1'b0);

    // Taken LE (N^V) redirect; counter wrap when the option is built
`ifdef DBS_PERF_CNT_EN
    dut.perf_cnt_q = 16'hFFFF;
`endif
    n_f = 1'b1; v_f = 1'b0; z_f = 1'b0; fv = 1'b1;
    push(1'b1, 8'hA5, C_LE, 1'b0, 8'h00, C_NV);
    fetch_only(2);
    step(2);
    check("le_redirect_pc", rpc, 9'h0A5);
    check("le_p0_do", p0_do, 1'b1);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    check("le_flush", flush, 1'b1);
`ifdef DBS_PERF_CNT_EN
    check("perf_wrap", perf, 16'd0);
`endif
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
